// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter whose state register advances only through per-bit J/K drives.
// JV/KV/TC are combinational so they can feed downstream jkff cells for the coming edge.
module jk_mod_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] JV,
    output logic [WIDTH-1:0] KV,
    output logic             TC
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    if ((MODULUS < 2) || (64'(MODULUS) > (64'(1) << WIDTH))) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] nxt;
    logic             at_wrap;

    // Intended next state; JV/KV are derived from it so that set/reset codes only.
    always_comb begin
        nxt = q_r;
        if (RST) begin
            nxt = '0;
        end else if (LOAD) begin
            nxt = (D > MAX_Q) ? MAX_Q : D;
        end else if (EN) begin
            if (UP) begin
                nxt = (q_r == MAX_Q) ? '0 : q_r + WIDTH'(1);
            end else begin
                nxt = (q_r == '0) ? MAX_Q : q_r - WIDTH'(1);
            end
        end
    end

    always_comb begin
        JV      = '0;
        KV      = '0;
        at_wrap = UP ? (q_r == MAX_Q) : (q_r == '0);
        if (!RST) begin
            JV = ~q_r & nxt;
            KV = q_r & ~nxt;
        end
        TC = EN & ~LOAD & ~RST & at_wrap;
    end

    // State advances strictly by the JK characteristic equation; reset overrides it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_r <= '0;
        end else begin
            q_r <= (JV & ~q_r) | (~KV & q_r);
        end
    end

    assign Q = q_r;

endmodule
